apb_fabric_master: RTL and testbench
====================================

APB_FABRIC_MASTER -- requirements
Module: apb_fabric_master

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, APB address width.
REQ-002 SHALL have parameter DATA_W, default 32, APB data width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 255, the maximum ACCESS wait cycles (range 1..255).
REQ-004 SHALL have one clock and synchronous active-low reset: PCLK  in  1  clock; PRESETN  in  1  sync reset, active low.
REQ-005 SHALL have command ports: CMD_VALID in 1; CMD_READY out 1; CMD_WRITE in 1 (1 = write); CMD_ADDR in ADDR_W; CMD_WDATA in DATA_W.
REQ-006 SHALL have response ports: RSP_VALID out 1; RSP_READY in 1; RSP_RDATA out DATA_W; RSP_ERR out 1; RSP_TIMEOUT out 1.
REQ-007 SHALL have APB3 master ports: PSEL out 1; PENABLE out 1; PWRITE out 1; PADDR out ADDR_W; PWDATA out DATA_W; PRDATA in DATA_W; PREADY in 1; PSLVERR in 1.
REQ-008 SHALL have BUSY out 1, high in every state except IDLE.

Function
REQ-009 SHALL implement the states IDLE, SETUP, ACCESS and RESP, with all outputs registered.
REQ-010 SHALL drive CMD_READY=1 only in IDLE; a command is accepted on a cycle with CMD_VALID&&CMD_READY, and the FSM moves to SETUP.
REQ-011 SHALL latch CMD_WRITE, CMD_ADDR and CMD_WDATA on acceptance and hold PWRITE, PADDR and PWDATA stable from SETUP through the last ACCESS cycle.
REQ-012 SHALL drive PSEL=1 and PENABLE=0 in SETUP for exactly one cycle, then move to ACCESS.
REQ-013 SHALL drive PSEL=1 and PENABLE=1 in ACCESS; with PREADY=0 it stays in ACCESS, and with PREADY=1 it moves to RESP with PSEL and PENABLE low on the next cycle.
REQ-014 SHALL give a zero-wait transfer this timing: accept at cycle N, SETUP at N+1, ACCESS at N+2, RSP_VALID at N+3.
REQ-015 SHALL sample PSLVERR into RSP_ERR only on the PREADY=1 ACCESS cycle.
REQ-016 SHALL capture PRDATA into RSP_RDATA only for reads; for writes RSP_RDATA SHALL be 0.
REQ-017 SHALL hold RSP_VALID, RSP_RDATA, RSP_ERR and RSP_TIMEOUT stable in RESP until RSP_READY=1, then return to IDLE on the next cycle.
REQ-018 SHALL make CMD_READY visible one cycle after the RSP handshake; there are no back-to-back commands.
REQ-019 SHALL ignore CMD_VALID in every non-IDLE state; no command is queued.
REQ-020 SHALL NOT let PSLVERR or PREADY outside ACCESS affect any state or output.

Reset
REQ-021 SHALL, on PRESETN=0 at a PCLK edge, force state IDLE and drive every output to 0 on the following cycle: PSEL, PENABLE, PWRITE, PADDR, PWDATA, CMD_READY, RSP_VALID, RSP_RDATA, RSP_ERR, RSP_TIMEOUT and BUSY. CMD_READY rises the first cycle after PRESETN returns to 1.
REQ-022 SHALL, on reset in mid-transfer, abandon the transfer without issuing a response.

Configuration
REQ-023 SHALL compile the ACCESS watchdog in only with APB_FABRIC_MASTER_TIMEOUT_EN defined.
REQ-024 SHALL, with APB_FABRIC_MASTER_TIMEOUT_EN defined, behave as follows:
- An 8-bit counter clears on entering ACCESS and increments on each ACCESS cycle with PREADY=0.
- When the count reaches TIMEOUT_CYCLES with PREADY still 0, the FSM moves to RESP with RSP_ERR=1, RSP_TIMEOUT=1 and RSP_RDATA=0.
- PSEL and PENABLE are dropped on that transition.
- If PREADY=1 arrives on the same cycle the limit is reached, PREADY wins and no timeout is reported.
REQ-025 SHALL, without APB_FABRIC_MASTER_TIMEOUT_EN, have no counter, wait indefinitely in ACCESS, and tie RSP_TIMEOUT to 0.

Structure
REQ-026 SHALL place the FSM state typedef, the default ADDR_W and DATA_W constants and the timeout counter width constant (8) in the shared package apb_fabric_pkg.
REQ-027 SHALL put the watchdog in one sub-module, apb_wait_timer (clear, count enable, limit reached), instantiated only under APB_FABRIC_MASTER_TIMEOUT_EN.

Verification
REQ-028 SHALL cover a zero-wait write: CMD addr 0x04, wdata 0x000003E8, PREADY=1 -> PSEL at N+1, PENABLE at N+2, RSP_VALID at N+3, RSP_ERR=0, RSP_RDATA=0.
REQ-029 SHALL cover a read with 3 wait states: addr 0x08, PREADY low 3 ACCESS cycles, PRDATA=0xDEADBEEF -> RSP_RDATA=0xDEADBEEF at N+6, PADDR stable throughout.
REQ-030 SHALL cover a slave error: PSLVERR=1 with PREADY=1 -> RSP_ERR=1; PSLVERR=1 while PREADY=0 -> ignored.
REQ-031 SHALL cover response backpressure: RSP_READY held low 5 cycles -> response fields stable, CMD_VALID pulses ignored, CMD_READY 1 cycle after the handshake.
REQ-032 SHALL cover reset in ACCESS: PRESETN=0 -> all outputs 0 next cycle, no RSP_VALID; after release CMD_READY=1.
REQ-033 SHALL cover the timeout (macro on, TIMEOUT_CYCLES=4): PREADY stuck low -> RSP_ERR=1, RSP_TIMEOUT=1 after 4 ACCESS cycles; with PREADY=1 on the 4th cycle -> normal completion.

Source files
------------

// File: rtl/apb_fabric_pkg.sv
// rtl/apb_fabric_pkg.sv - shared state encoding and width constants for the APB fabric master
package apb_fabric_pkg;

    localparam int APB_ADDR_W_DEF = 8;
    localparam int APB_DATA_W_DEF = 32;
    localparam int TMO_CNT_W      = 8;

    typedef logic [1:0] apb_state_t;

    localparam apb_state_t ST_IDLE   = 2'd0;
    localparam apb_state_t ST_SETUP  = 2'd1;
    localparam apb_state_t ST_ACCESS = 2'd2;
    localparam apb_state_t ST_RESP   = 2'd3;

endpackage

// File: rtl/apb_wait_timer.sv
// rtl/apb_wait_timer.sv - ACCESS-phase wait counter; limit_o flags the wait cycle that exhausts LIMIT
module apb_wait_timer
    import apb_fabric_pkg::*;
#(
    parameter int LIMIT = 255
) (
    input  logic clk_i,
    input  logic resetn_i,
    input  logic clear_i,
    input  logic count_en_i,
    output logic limit_o
);

    logic [TMO_CNT_W-1:0] cnt_q;
    logic [TMO_CNT_W-1:0] cnt_d;

    // The count after this wait cycle would equal LIMIT.
    assign limit_o = (cnt_q == TMO_CNT_W'(LIMIT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (count_en_i && !limit_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/apb_fabric_master.sv
// rtl/apb_fabric_master.sv - single-outstanding command-to-APB3 master with registered outputs
// Optional ACCESS watchdog enabled by defining APB_FABRIC_MASTER_TIMEOUT_EN.
module apb_fabric_master
    import apb_fabric_pkg::*;
#(
    parameter int ADDR_W         = APB_ADDR_W_DEF,
    parameter int DATA_W         = APB_DATA_W_DEF,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              PCLK,
    input  logic              PRESETN,
    input  logic              CMD_VALID,
    output logic              CMD_READY,
    input  logic              CMD_WRITE,
    input  logic [ADDR_W-1:0] CMD_ADDR,
    input  logic [DATA_W-1:0] CMD_WDATA,
    output logic              RSP_VALID,
    input  logic              RSP_READY,
    output logic [DATA_W-1:0] RSP_RDATA,
    output logic              RSP_ERR,
    output logic              RSP_TIMEOUT,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY,
    input  logic              PSLVERR,
    output logic              BUSY
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be in 1..255");
    end

    apb_state_t state_q;
    apb_state_t state_d;

    logic              cmd_ready_q;
    logic              busy_q;
    logic              psel_q;
    logic              penable_q;
    logic              pwrite_q;
    logic [ADDR_W-1:0] paddr_q;
    logic [DATA_W-1:0] pwdata_q;
    logic              rsp_valid_q;
    logic [DATA_W-1:0] rsp_rdata_q;
    logic              rsp_err_q;

    logic accept;
    logic in_access;
    logic timed_out;
    logic finish;

    assign accept    = CMD_VALID && cmd_ready_q;
    assign in_access = (state_q == ST_ACCESS);

`ifdef APB_FABRIC_MASTER_TIMEOUT_EN
    logic limit_hit;
    logic rsp_timeout_q;

    apb_wait_timer #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_wait_timer (
        .clk_i      (PCLK),
        .resetn_i   (PRESETN),
        .clear_i    (state_q == ST_SETUP),
        .count_en_i (in_access && !PREADY),
        .limit_o    (limit_hit)
    );

    // A PREADY arriving on the limit cycle still completes normally.
    assign timed_out   = in_access && !PREADY && limit_hit;
    assign RSP_TIMEOUT = rsp_timeout_q;
`else
    assign timed_out   = 1'b0;
    assign RSP_TIMEOUT = 1'b0;
`endif

    assign finish = in_access && (PREADY || timed_out);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (accept)    state_d = ST_SETUP;
            ST_SETUP:                 state_d = ST_ACCESS;
            ST_ACCESS: if (finish)    state_d = ST_RESP;
            ST_RESP:   if (RSP_READY) state_d = ST_IDLE;
            default:                  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (!PRESETN) begin
            state_q     <= ST_IDLE;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= (state_d == ST_IDLE);
            busy_q      <= (state_d != ST_IDLE);
            psel_q      <= (state_d == ST_SETUP) || (state_d == ST_ACCESS);
            penable_q   <= (state_d == ST_ACCESS);
            if (accept) begin
                pwrite_q <= CMD_WRITE;
                paddr_q  <= CMD_ADDR;
                pwdata_q <= CMD_WDATA;
            end
            if (finish) begin
                rsp_valid_q <= 1'b1;
                rsp_err_q   <= PREADY ? PSLVERR : 1'b1;
                rsp_rdata_q <= (PREADY && !pwrite_q) ? PRDATA : '0;
            end else if ((state_q == ST_RESP) && RSP_READY) begin
                rsp_valid_q <= 1'b0;
            end
        end
    end

`ifdef APB_FABRIC_MASTER_TIMEOUT_EN
    always_ff @(posedge PCLK) begin
        if (!PRESETN) begin
            rsp_timeout_q <= 1'b0;
        end else if (finish) begin
            rsp_timeout_q <= timed_out;
        end
    end
`endif

    assign CMD_READY = cmd_ready_q;
    assign BUSY      = busy_q;
    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;
    assign PWRITE    = pwrite_q;
    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;
    assign RSP_VALID = rsp_valid_q;
    assign RSP_RDATA = rsp_rdata_q;
    assign RSP_ERR   = rsp_err_q;

endmodule

// File: tb/tb_apb_fabric_master.sv
// tb/tb_apb_fabric_master.sv - directed self-checking bench for apb_fabric_master
module tb_apb_fabric_master;

    logic        PCLK;
    logic        PRESETN;
    logic        CMD_VALID;
    logic        CMD_READY;
    logic        CMD_WRITE;
    logic [7:0]  CMD_ADDR;
    logic [31:0] CMD_WDATA;
    logic        RSP_VALID;
    logic        RSP_READY;
    logic [31:0] RSP_RDATA;
    logic        RSP_ERR;
    logic        RSP_TIMEOUT;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [7:0]  PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;
    logic        BUSY;

    int checks;
    int failures;

    apb_fabric_master #(
        .ADDR_W         (8),
        .DATA_W         (32),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .PCLK        (PCLK),
        .PRESETN     (PRESETN),
        .CMD_VALID   (CMD_VALID),
        .CMD_READY   (CMD_READY),
        .CMD_WRITE   (CMD_WRITE),
        .CMD_ADDR    (CMD_ADDR),
        .CMD_WDATA   (CMD_WDATA),
        .RSP_VALID   (RSP_VALID),
        .RSP_READY   (RSP_READY),
        .RSP_RDATA   (RSP_RDATA),
        .RSP_ERR     (RSP_ERR),
        .RSP_TIMEOUT (RSP_TIMEOUT),
        .PSEL        (PSEL),
        .PENABLE     (PENABLE),
        .PWRITE      (PWRITE),
        .PADDR       (PADDR),
        .PWDATA      (PWDATA),
        .PRDATA      (PRDATA),
        .PREADY      (PREADY),
        .PSLVERR     (PSLVERR),
        .BUSY        (BUSY)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic step();
        @(negedge PCLK);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_psel"},      PSEL,        0);
        chk({tag, "_penable"},   PENABLE,     0);
        chk({tag, "_pwrite"},    PWRITE,      0);
        chk({tag, "_paddr"},     PADDR,       0);
        chk({tag, "_pwdata"},    PWDATA,      0);
        chk({tag, "_cmd_ready"}, CMD_READY,   0);
        chk({tag, "_rsp_valid"}, RSP_VALID,   0);
        chk({tag, "_rsp_rdata"}, RSP_RDATA,   0);
        chk({tag, "_rsp_err"},   RSP_ERR,     0);
        chk({tag, "_rsp_tmo"},   RSP_TIMEOUT, 0);
        chk({tag, "_busy"},      BUSY,        0);
    endtask

    task automatic issue(input logic wr, input logic [7:0] addr, input logic [31:0] wdata);
        CMD_VALID = 1'b1;
        CMD_WRITE = wr;
        CMD_ADDR  = addr;
        CMD_WDATA = wdata;
        step();
        CMD_VALID = 1'b0;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        PRESETN   = 1'b0;
        CMD_VALID = 1'b0;
        CMD_WRITE = 1'b0;
        CMD_ADDR  = '0;
        CMD_WDATA = '0;
        RSP_READY = 1'b1;
        PRDATA    = '0;
        PREADY    = 1'b0;
        PSLVERR   = 1'b0;

        // Reset state and CMD_READY rising one cycle after release
        step();
        step();
        chk_all_zero("reset");
        PRESETN = 1'b1;
        step();
        chk("rel_cmd_ready", CMD_READY, 1);
        chk("rel_busy", BUSY, 0);

        // Zero-wait write
        PREADY = 1'b1;
        PRDATA = 32'h1234_5678;
        issue(1'b1, 8'h04, 32'h0000_03E8);
        chk("wr_setup_psel", PSEL, 1);
        chk("wr_setup_penable", PENABLE, 0);
        chk("wr_setup_pwrite", PWRITE, 1);
        chk("wr_setup_paddr", PADDR, 32'h04);
        chk("wr_setup_pwdata", PWDATA, 32'h0000_03E8);
        chk("wr_setup_cmd_ready", CMD_READY, 0);
        chk("wr_setup_busy", BUSY, 1);
        step();
        chk("wr_access_psel", PSEL, 1);
        chk("wr_access_penable", PENABLE, 1);
        chk("wr_access_rsp_valid", RSP_VALID, 0);
        step();
        chk("wr_rsp_valid", RSP_VALID, 1);
        chk("wr_rsp_psel", PSEL, 0);
        chk("wr_rsp_penable", PENABLE, 0);
        chk("wr_rsp_err", RSP_ERR, 0);
        chk("wr_rsp_rdata", RSP_RDATA, 0);
        chk("wr_rsp_tmo", RSP_TIMEOUT, 0);
        step();
        chk("wr_done_rsp_valid", RSP_VALID, 0);
        chk("wr_done_cmd_ready", CMD_READY, 1);
        chk("wr_done_busy", BUSY, 0);

        // Read with three wait states; PSLVERR during waits must be ignored
        PREADY = 1'b0;
        PRDATA = 32'hDEAD_BEEF;
        issue(1'b0, 8'h08, 32'h0000_FFFF);
        PSLVERR = 1'b1;
        chk("rd_setup_penable", PENABLE, 0);
        chk("rd_setup_pwrite", PWRITE, 0);
        chk("rd_setup_paddr", PADDR, 32'h08);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("rd_wait_penable", PENABLE, 1);
            chk("rd_wait_paddr", PADDR, 32'h08);
            chk("rd_wait_rsp_valid", RSP_VALID, 0);
        end
        step();
        chk("rd_last_penable", PENABLE, 1);
        chk("rd_last_paddr", PADDR, 32'h08);
        PREADY  = 1'b1;
        PSLVERR = 1'b0;
        step();
        chk("rd_rsp_valid", RSP_VALID, 1);
        chk("rd_rsp_rdata", RSP_RDATA, 32'hDEAD_BEEF);
        chk("rd_rsp_err", RSP_ERR, 0);
        step();
        chk("rd_done_cmd_ready", CMD_READY, 1);

        // Slave error on a read, then response backpressure with ignored commands
        RSP_READY = 1'b0;
        PSLVERR   = 1'b1;
        PRDATA    = 32'hA5A5_0001;
        issue(1'b0, 8'h10, 32'h0);
        step();
        step();
        chk("err_rsp_valid", RSP_VALID, 1);
        chk("err_rsp_err", RSP_ERR, 1);
        chk("err_rsp_rdata", RSP_RDATA, 32'hA5A5_0001);
        PSLVERR = 1'b0;
        for (int i = 0; i < 5; i++) begin
            CMD_VALID = i[0];
            CMD_ADDR  = 8'h40;
            PRDATA    = i;
            step();
            chk("bp_rsp_valid", RSP_VALID, 1);
            chk("bp_rsp_err", RSP_ERR, 1);
            chk("bp_rsp_rdata", RSP_RDATA, 32'hA5A5_0001);
            chk("bp_cmd_ready", CMD_READY, 0);
            chk("bp_psel", PSEL, 0);
        end
        CMD_VALID = 1'b0;
        RSP_READY = 1'b1;
        step();
        chk("bp_done_rsp_valid", RSP_VALID, 0);
        chk("bp_done_cmd_ready", CMD_READY, 1);
        step();
        chk("bp_idle_psel", PSEL, 0);
        chk("bp_idle_paddr", PADDR, 32'h10);

        // Reset while in ACCESS abandons the transfer
        PREADY = 1'b0;
        issue(1'b1, 8'h30, 32'h0000_CAFE);
        step();
        chk("rst_pre_penable", PENABLE, 1);
        PRESETN = 1'b0;
        step();
        chk_all_zero("rst_access");
        PRESETN = 1'b1;
        PREADY  = 1'b1;
        step();
        chk("rst_rel_cmd_ready", CMD_READY, 1);
        chk("rst_rel_rsp_valid", RSP_VALID, 0);
        chk("rst_rel_psel", PSEL, 0);

`ifdef APB_FABRIC_MASTER_TIMEOUT_EN
        // Watchdog: PREADY stuck low for four ACCESS cycles
        PREADY = 1'b0;
        PRDATA = 32'h0000_0077;
        issue(1'b0, 8'h20, 32'h0);
        for (int k = 0; k < 4; k++) begin
            step();
            chk("tmo_wait_penable", PENABLE, 1);
        end
        step();
        chk("tmo_rsp_valid", RSP_VALID, 1);
        chk("tmo_rsp_err", RSP_ERR, 1);
        chk("tmo_rsp_tmo", RSP_TIMEOUT, 1);
        chk("tmo_rsp_rdata", RSP_RDATA, 0);
        chk("tmo_psel", PSEL, 0);
        chk("tmo_penable", PENABLE, 0);
        step();
        chk("tmo_done_cmd_ready", CMD_READY, 1);

        // PREADY on the limit cycle wins
        issue(1'b0, 8'h24, 32'h0);
        for (int k = 0; k < 4; k++) begin
            step();
            chk("tmo_race_penable", PENABLE, 1);
        end
        PREADY = 1'b1;
        PRDATA = 32'h0000_0055;
        step();
        chk("tmo_race_rsp_valid", RSP_VALID, 1);
        chk("tmo_race_rsp_err", RSP_ERR, 0);
        chk("tmo_race_rsp_tmo", RSP_TIMEOUT, 0);
        chk("tmo_race_rsp_rdata", RSP_RDATA, 32'h0000_0055);
        step();
`else
        // Without the watchdog a stalled slave is waited on indefinitely
        PREADY = 1'b0;
        PRDATA = 32'h0000_0055;
        issue(1'b0, 8'h20, 32'h0);
        for (int k = 0; k < 10; k++) begin
            step();
        end
        chk("nowd_penable", PENABLE, 1);
        chk("nowd_rsp_valid", RSP_VALID, 0);
        chk("nowd_rsp_tmo", RSP_TIMEOUT, 0);
        PREADY = 1'b1;
        step();
        chk("nowd_rsp_valid_end", RSP_VALID, 1);
        chk("nowd_rsp_err", RSP_ERR, 0);
        chk("nowd_rsp_tmo_end", RSP_TIMEOUT, 0);
        chk("nowd_rsp_rdata", RSP_RDATA, 32'h0000_0055);
        step();
`endif
        chk("final_cmd_ready", CMD_READY, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
